// File: rtl/sensor_conditioner.sv
// sensor_conditioner: conditions the raw occupancy sensor, ambient light reading
// and colour button into clean, registered control flags for the lamp controller.
// Handshake note: this block has no valid/ready interfaces. Every output is a
// level that is valid on every cycle and updates only on the rising clock edge.
module sensor_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES     = 1000,
  parameter logic [7:0]  DARK_ON         = 8'd60,
  parameter logic [7:0]  DARK_OFF        = 8'd80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pir_raw,
  input  logic [7:0] light_level,
  input  logic       btn_raw,
  output logic       motion,
  output logic       dark,
  output logic [2:0] color_select,
  output logic [1:0] o_dbg_state
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HC_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HC_W-1:0] HOLD_LOAD = HC_W'(HOLD_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  logic            r_pir_s1, r_pir_s2;
  logic            r_btn_s1, r_btn_s2;
  logic [1:0]      r_sync_vld;
  logic            r_pir_deb, r_btn_deb;
  logic [DB_W-1:0] r_pir_cnt, r_btn_cnt;
  logic [DB_W-1:0] r_arm_cnt;
  logic            r_btn_armed;
  logic [1:0]      r_state;
  logic [HC_W-1:0] r_hold_cnt;
  logic [7:0]      r_light;
  logic            r_light_vld;
  logic            r_dark;
  logic [2:0]      r_color;

  logic w_pir_diff, w_btn_diff, w_btn_rise;

  assign w_pir_diff = r_pir_s2 ^ r_pir_deb;
  assign w_btn_diff = r_btn_s2 ^ r_btn_deb;
  // Debounced button is about to flip from released to pressed on this edge.
  assign w_btn_rise = w_btn_diff & ~r_btn_deb & (r_btn_cnt == DB_LAST);

  // Two-flop synchronizers; r_sync_vld marks when the second flop holds a real sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pir_s1   <= 1'b0;
      r_pir_s2   <= 1'b0;
      r_btn_s1   <= 1'b0;
      r_btn_s2   <= 1'b0;
      r_sync_vld <= 2'b00;
    end else begin
      r_pir_s1   <= pir_raw;
      r_pir_s2   <= r_pir_s1;
      r_btn_s1   <= btn_raw;
      r_btn_s2   <= r_btn_s1;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
    end
  end

  // PIR debounce: flip only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pir_deb <= 1'b0;
      r_pir_cnt <= '0;
    end else if (!w_pir_diff) begin
      r_pir_cnt <= '0;
    end else if (r_pir_cnt == DB_LAST) begin
      r_pir_deb <= r_pir_s2;
      r_pir_cnt <= '0;
    end else begin
      r_pir_cnt <= r_pir_cnt + 1'b1;
    end
  end

  // Button debounce: same rule as the PIR path, with its own counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_deb <= 1'b0;
      r_btn_cnt <= '0;
    end else if (!w_btn_diff) begin
      r_btn_cnt <= '0;
    end else if (r_btn_cnt == DB_LAST) begin
      r_btn_deb <= r_btn_s2;
      r_btn_cnt <= '0;
    end else begin
      r_btn_cnt <= r_btn_cnt + 1'b1;
    end
  end

  // Arm the colour counter only after a debounced release has been seen since
  // reset, so a button held through reset cannot count as a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_armed <= 1'b0;
      r_arm_cnt   <= '0;
    end else if (!r_btn_armed && r_sync_vld[1]) begin
      if (r_btn_s2) begin
        r_arm_cnt <= '0;
      end else if (r_arm_cnt == DB_LAST) begin
        r_btn_armed <= 1'b1;
      end else begin
        r_arm_cnt <= r_arm_cnt + 1'b1;
      end
    end
  end

  // Colour code advances 0..4 and wraps, once per debounced press.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_color <= 3'd0;
    end else if (w_btn_rise && r_btn_armed) begin
      r_color <= (r_color == 3'd4) ? 3'd0 : r_color + 3'd1;
    end
  end

  // Motion FSM: ACTIVE while occupied, HOLD counts down the hang time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_pir_deb) r_state <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (!r_pir_deb) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          if (r_pir_deb) begin
            r_state <= ST_ACTIVE;
          end else if (r_hold_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Light register plus hysteresis comparator; dark is held until the
  // light register carries a real post-reset sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_light     <= 8'd0;
      r_light_vld <= 1'b0;
      r_dark      <= 1'b0;
    end else begin
      r_light     <= light_level;
      r_light_vld <= 1'b1;
      if (r_light_vld) begin
        if (r_light <= DARK_ON) begin
          r_dark <= 1'b1;
        end else if (r_light >= DARK_OFF) begin
          r_dark <= 1'b0;
        end
      end
    end
  end

  assign motion       = (r_state != ST_IDLE);
  assign dark         = r_dark;
  assign color_select = r_color;
  assign o_dbg_state  = r_state;

endmodule
